// File: rtl/au_inc_gray_reg.sv
// Registered Gray-code incrementer: z <= G(G^-1(a) + 1) one cycle after an accepted a.
// ARCH=1 builds the Gray->binary and carry logic as log-depth prefix trees; other values ripple.
module au_inc_gray_reg #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic [WIDTH-1:0] z
);
    localparam int STAGES = 1;
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]  bin;
    logic [WIDTH-1:0]  nxt_bin;
    logic [WIDTH-1:0]  nxt_gray;
    logic [STAGES:0]   vld_pipe;

    generate
        if (ARCH == 1) begin : g_prefix
            // px: suffix XOR toward the LSB; pa: prefix AND toward the MSB.
            logic [LEVELS:0][WIDTH-1:0] px;
            logic [LEVELS:0][WIDTH-1:0] pa;
            logic [WIDTH-1:0]           carry;

            assign px[0] = a;
            for (genvar l = 0; l < LEVELS; l++) begin : g_xlvl
                localparam int D = 1 << l;
                for (genvar i = 0; i < WIDTH; i++) begin : g_xbit
                    if (i + D < WIDTH) begin : g_op
                        assign px[l+1][i] = px[l][i] ^ px[l][i+D];
                    end else begin : g_pass
                        assign px[l+1][i] = px[l][i];
                    end
                end
            end
            assign bin = px[LEVELS];

            assign pa[0] = bin;
            for (genvar l = 0; l < LEVELS; l++) begin : g_alvl
                localparam int D = 1 << l;
                for (genvar i = 0; i < WIDTH; i++) begin : g_abit
                    if (i >= D) begin : g_op
                        assign pa[l+1][i] = pa[l][i] & pa[l][i-D];
                    end else begin : g_pass
                        assign pa[l+1][i] = pa[l][i];
                    end
                end
            end

            // Bit i toggles when every lower binary bit is 1; bit 0 always toggles.
            assign carry[0] = 1'b1;
            for (genvar i = 1; i < WIDTH; i++) begin : g_carry
                assign carry[i] = pa[LEVELS][i-1];
            end
            assign nxt_bin = bin ^ carry;
        end else begin : g_ripple
            logic c;
            always_comb begin
                bin          = '0;
                nxt_bin      = '0;
                c            = 1'b1;
                bin[WIDTH-1] = a[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    bin[i] = bin[i+1] ^ a[i];
                end
                for (int i = 0; i < WIDTH; i++) begin
                    nxt_bin[i] = bin[i] ^ c;
                    c          = c & bin[i];
                end
            end
        end
    endgenerate

    assign nxt_gray    = nxt_bin ^ (nxt_bin >> 1);
    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            z                  <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (in_valid) begin
                z <= nxt_gray;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_au_inc_gray_reg.sv
// Directed and exhaustive/random checks of au_inc_gray_reg across widths 1/8/16/32/64 and both ARCH values.
module tb_au_inc_gray_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        a1;
    logic [7:0]  a8;
    logic [15:0] a16;
    logic [31:0] a32;
    logic [63:0] a64;
    logic        z1;
    logic [7:0]  z8_0, z8_1;
    logic [15:0] z16_0, z16_1;
    logic [31:0] z32_0, z32_1;
    logic [63:0] z64_0, z64_1;
    logic        v1, v8_0, v8_1, v16_0, v16_1, v32_0, v32_1, v64_0, v64_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    au_inc_gray_reg #(.WIDTH(1),  .ARCH(0)) u_w1   (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1),  .out_valid(v1),    .z(z1));
    au_inc_gray_reg #(.WIDTH(8),  .ARCH(0)) u_w8a0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8),  .out_valid(v8_0),  .z(z8_0));
    au_inc_gray_reg #(.WIDTH(8),  .ARCH(1)) u_w8a1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8),  .out_valid(v8_1),  .z(z8_1));
    au_inc_gray_reg #(.WIDTH(16), .ARCH(0)) u_w16a0(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .out_valid(v16_0), .z(z16_0));
    au_inc_gray_reg #(.WIDTH(16), .ARCH(1)) u_w16a1(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .out_valid(v16_1), .z(z16_1));
    au_inc_gray_reg #(.WIDTH(32), .ARCH(0)) u_w32a0(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a32), .out_valid(v32_0), .z(z32_0));
    au_inc_gray_reg #(.WIDTH(32), .ARCH(1)) u_w32a1(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a32), .out_valid(v32_1), .z(z32_1));
    au_inc_gray_reg #(.WIDTH(64), .ARCH(0)) u_w64a0(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a64), .out_valid(v64_0), .z(z64_0));
    au_inc_gray_reg #(.WIDTH(64), .ARCH(1)) u_w64a1(.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a64), .out_valid(v64_1), .z(z64_1));

    function automatic logic [63:0] ginc(input logic [63:0] g, input int w);
        logic [63:0] b, n, m;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        b = '0;
        b[w-1] = g[w-1];
        for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        n = (b + 64'd1) & m;
        return (n ^ (n >> 1)) & m;
    endfunction

    // Advance one edge; outputs are examined 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a8 = 8'h55; a16 = 16'h5555; a1 = 1'b1;
        a32 = 32'h5555_5555; a64 = 64'h5555_5555_5555_5555;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (z8_0 !== 8'h00 || v8_0 !== 1'b0) begin
                errors++; $display("FAIL reset8a0 cyc%0d got z=%h v=%b want z=00 v=0", c, z8_0, v8_0);
            end
            checks++;
            if (z8_1 !== 8'h00 || v8_1 !== 1'b0) begin
                errors++; $display("FAIL reset8a1 cyc%0d got z=%h v=%b want z=00 v=0", c, z8_1, v8_1);
            end
            checks++;
            if (z64_1 !== 64'h0 || v64_1 !== 1'b0 || z16_0 !== 16'h0 || v16_0 !== 1'b0) begin
                errors++; $display("FAIL reset_wide cyc%0d got z64=%h v64=%b z16=%h v16=%b want zeros", c, z64_1, v64_1, z16_0, v16_0);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] vin [4];
        logic [7:0] vexp [4];
        vin  = '{8'h00, 8'h01, 8'h03, 8'h02};
        vexp = '{8'h01, 8'h03, 8'h02, 8'h06};
        rst_n = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a8 = vin[k];
            tick();
            checks++;
            if (z8_0 !== vexp[k] || v8_0 !== 1'b1) begin
                errors++; $display("FAIL basic_a0 a=%h got z=%h v=%b want z=%h v=1", vin[k], z8_0, v8_0, vexp[k]);
            end
            checks++;
            if (z8_1 !== vexp[k] || v8_1 !== 1'b1) begin
                errors++; $display("FAIL basic_a1 a=%h got z=%h v=%b want z=%h v=1", vin[k], z8_1, v8_1, vexp[k]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] vin [2];
        logic [7:0] vexp [2];
        vin  = '{8'h80, 8'hFF};
        vexp = '{8'h00, 8'hFE};
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a8 = vin[k];
            tick();
            checks++;
            if (z8_0 !== vexp[k] || z8_1 !== vexp[k]) begin
                errors++; $display("FAIL boundary a=%h got a0=%h a1=%h want %h", vin[k], z8_0, z8_1, vexp[k]);
            end
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a8 = 8'h03;
        tick();
        checks++;
        if (z8_0 !== 8'h02 || v8_0 !== 1'b1) begin
            errors++; $display("FAIL hold_load got z=%h v=%b want z=02 v=1", z8_0, v8_0);
        end
        in_valid = 1'b0; a8 = 8'hAA;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (z8_0 !== 8'h02 || v8_0 !== 1'b0 || z8_1 !== 8'h02 || v8_1 !== 1'b0) begin
                errors++; $display("FAIL hold_idle cyc%0d got z=%h/%h v=%b/%b want z=02 v=0", c, z8_0, z8_1, v8_0, v8_1);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a8 = 8'h01;
        tick();
        checks++;
        if (z8_0 !== 8'h03 || v8_0 !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got z=%h v=%b want z=03 v=1", z8_0, v8_0);
        end
        rst_n = 1'b0; a8 = 8'h03;
        tick();
        checks++;
        if (z8_0 !== 8'h00 || v8_0 !== 1'b0 || z8_1 !== 8'h00 || v8_1 !== 1'b0) begin
            errors++; $display("FAIL midrst got z=%h/%h v=%b/%b want z=00 v=0", z8_0, z8_1, v8_0, v8_1);
        end
        rst_n = 1'b1; a8 = 8'h02;
        tick();
        checks++;
        if (z8_0 !== 8'h06 || v8_0 !== 1'b1) begin
            errors++; $display("FAIL midrst_post got z=%h v=%b want z=06 v=1", z8_0, v8_0);
        end
    endtask

    task automatic test_width1();
        in_valid = 1'b1;
        a1 = 1'b0;
        tick();
        checks++;
        if (z1 !== 1'b1 || v1 !== 1'b1) begin
            errors++; $display("FAIL w1_a0 got z=%b v=%b want z=1 v=1", z1, v1);
        end
        a1 = 1'b1;
        tick();
        checks++;
        if (z1 !== 1'b0) begin
            errors++; $display("FAIL w1_a1 got z=%b want 0", z1);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] e16;
        logic [7:0]  e8;
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            a16 = 16'(i);
            a8  = 8'(i);
            e16 = 16'(ginc(64'(a16), 16));
            e8  = 8'(ginc(64'(a8), 8));
            tick();
            checks++;
            if (z16_0 !== e16 || z16_1 !== e16 || v16_0 !== 1'b1 || v16_1 !== 1'b1) begin
                errors++; $display("FAIL exh16 a=%h got a0=%h a1=%h want %h", a16, z16_0, z16_1, e16);
            end
            checks++;
            if ($countones(z16_0 ^ a16) != 1 || $countones(z16_1 ^ a16) != 1) begin
                errors++; $display("FAIL hamming16 a=%h got a0=%h a1=%h want distance 1", a16, z16_0, z16_1);
            end
            if (i < 256) begin
                checks++;
                if (z8_0 !== e8 || z8_1 !== e8 || $countones(z8_0 ^ a8) != 1) begin
                    errors++; $display("FAIL exh8 a=%h got a0=%h a1=%h want %h", a8, z8_0, z8_1, e8);
                end
            end
        end
    endtask

    task automatic test_wide();
        logic [31:0] e32;
        logic [63:0] e64;
        in_valid = 1'b1;
        a32 = '0; a64 = '0;
        tick();
        checks++;
        if (z32_0 !== 32'h1 || z32_1 !== 32'h1 || z64_0 !== 64'h1 || z64_1 !== 64'h1) begin
            errors++; $display("FAIL wide_zero got %h %h %h %h want 1", z32_0, z32_1, z64_0, z64_1);
        end
        a32 = '1; a64 = '1;
        tick();
        checks++;
        if (z32_0 !== 32'hFFFF_FFFE || z32_1 !== 32'hFFFF_FFFE ||
            z64_0 !== 64'hFFFF_FFFF_FFFF_FFFE || z64_1 !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL wide_ones got %h %h %h %h want FF..FE", z32_0, z32_1, z64_0, z64_1);
        end
        for (int k = 0; k < 10000; k++) begin
            a32 = $urandom;
            a64 = {$urandom, $urandom};
            e32 = 32'(ginc(64'(a32), 32));
            e64 = ginc(a64, 64);
            tick();
            checks++;
            if (z32_0 !== e32 || z32_1 !== e32) begin
                errors++; $display("FAIL rand32 a=%h got a0=%h a1=%h want %h", a32, z32_0, z32_1, e32);
            end
            checks++;
            if (z64_0 !== e64 || z64_1 !== e64) begin
                errors++; $display("FAIL rand64 a=%h got a0=%h a1=%h want %h", a64, z64_0, z64_1, e64);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; a8 = '0; a16 = '0; a32 = '0; a64 = '0;
        #1;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_reset_mid();
        test_width1();
        test_exhaustive();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/au_inc_gray_reg.md
Name: au_inc_gray_reg

Overview:
- Registered Gray-code incrementer.
- Takes a WIDTH-bit Gray-coded word and returns, one clock later, the Gray code of the next count value. The next count wraps modulo 2^WIDTH.
- Used as the building block for Gray counters and async-FIFO pointers in the arithmetic-unit library.
- ARCH selects the internal implementation. Results are bit-identical for every ARCH value.

Parameters:
- WIDTH, 8, word length of a and z; legal range 1..64.
- ARCH, 0, implementation select:
  - 0: Gray->binary prefix-XOR, binary +1 ripple, binary->Gray.
  - 1: parallel-prefix (log-depth) Gray->binary and carry chain.
  - Any other value behaves as 0.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, a is sampled on this clock edge when high.
- a, input, WIDTH, Gray-coded input value.
- out_valid, output, 1, high for one cycle after each accepted input.
- z, output, WIDTH, Gray-coded incremented value (registered).

Behaviour:
- Function, with G(x) = x ^ (x >> 1) and G^-1 the inverse Gray map:
  - b = G^-1(a), where b[WIDTH-1] = a[WIDTH-1] and b[i] = b[i+1] ^ a[i].
  - n = (b + 1) mod 2^WIDTH; the carry-out is discarded.
  - z = G(n) = n ^ (n >> 1).
- Result is defined for every input pattern. There are no illegal codes, and every WIDTH-bit word is a valid Gray code.
- Wrap-around: a = G(2^WIDTH - 1), i.e. MSB=1 and all other bits 0, gives z = 0.
- For every a, z differs from a in exactly one bit position.
- WIDTH=1: a=0 gives z=1; a=1 gives z=0.
- Timing:
  - On a rising clk edge with rst_n=1 and in_valid=1: z <= f(a) and out_valid <= 1.
  - With rst_n=1 and in_valid=0: z holds its value and out_valid <= 0.
  - Latency is exactly 1 cycle. Throughput is one word per cycle, back-to-back.
- Reset:
  - On a rising edge with rst_n=0: z <= 0 and out_valid <= 0.
  - Reset has priority over a simultaneous in_valid.
  - An input presented in the same cycle as reset is dropped.
  - Reset asserted mid-stream discards any pending result.
- No X propagation: outputs are known from the first clock with rst_n=0.
- Internal datapath is purely combinational from a to the z register D-input. There are no multicycle paths.
- ARCH=1 computes the prefix XOR and the carry propagate (AND of low binary bits) with a Kogge-Stone/Sklansky tree. Output must equal ARCH=0 for every input.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and a=8'h55 -> z=8'h00 and out_valid=0 throughout. Release reset -> the first accepted a appears next cycle.
- Basic sequence, WIDTH=8, back-to-back in_valid=1:
  - 8'h00 -> 8'h01.
  - 8'h01 -> 8'h03.
  - 8'h03 -> 8'h02.
  - 8'h02 -> 8'h06.
  - Each result appears one cycle after its input, with out_valid=1.
- Boundaries, WIDTH=8:
  - a=8'h80 (binary 255) -> z=8'h00 (wrap).
  - a=8'hFF (binary 170) -> z=8'hFE.
- Hold: drop in_valid after a=8'h03 -> z stays 8'h02 and out_valid returns to 0 while idle.
- Exhaustive, WIDTH<=16, for ARCH=0 and ARCH=1:
  - All 2^WIDTH inputs -> z equals G((G^-1(a)+1) mod 2^WIDTH).
  - z has Hamming distance 1 from a.
  - ARCH=0 and ARCH=1 outputs are identical.
- Wide random, WIDTH=32 and WIDTH=64: the all-0 and all-1 inputs plus 10000 random inputs -> match the same model. Specifically, all-1 gives the pattern 0xFF..FE.
